// File: rtl/stepper_pkg.sv
// stepper_pkg
// Shared types and constants for the stepper phase generator slice:
//   PERIOD_W / IDX_W widths, the coil excitation table, the FSM state type
//   and the per-tick index step size helper.
package stepper_pkg;

    localparam int unsigned PERIOD_W = 21;
    localparam int unsigned IDX_W    = 3;

    // Coil patterns {A,B,C,D}, entry 0 in the least significant nibble.
    // Odd entries energise two coils (full-step), all eight form half-step.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Full-step from an odd index jumps two entries; an even index left over
    // from half-step moves one entry so full-step realigns to odd.
    function automatic logic [IDX_W-1:0] step_size(input logic [IDX_W-1:0] idx,
                                                   input logic             full);
        return (full && idx[0]) ? IDX_W'(2) : IDX_W'(1);
    endfunction

endpackage

// File: rtl/stepper_phase_gen_if.sv
// stepper_phase_gen_if
// Bundles the speed-controller inputs and motor-driver outputs of the
// stepper phase generator.
//   master: drives en/dir/step/count_to, observes coils/step_tick/running
//   slave : the phase generator itself
// position is present only when STEPPER_POS_COUNT_EN is defined.
interface stepper_phase_gen_if;

    logic                              en;
    logic                              dir;
    logic                              step;
    logic [stepper_pkg::PERIOD_W-1:0]  count_to;
    logic [3:0]                        coils;
    logic                              step_tick;
    logic                              running;
`ifdef STEPPER_POS_COUNT_EN
    logic signed [31:0]                position;
`endif

    modport master (
        output en, dir, step, count_to,
        input  coils, step_tick, running
`ifdef STEPPER_POS_COUNT_EN
        , input position
`endif
    );

    modport slave (
        input  en, dir, step, count_to,
        output coils, step_tick, running
`ifdef STEPPER_POS_COUNT_EN
        , output position
`endif
    );

endinterface

// File: rtl/step_period_timer.sv
// step_period_timer
// Divides clk down to step ticks. The period register is loaded on run
// entry (load) and on every tick, so a count_to change lands on the next
// period. count_to == 0 is treated as 1 (tick every cycle).
//   clk, rst  : clock, synchronous active-low reset
//   load      : IDLE->RUN entry edge, captures count_to
//   run       : counter enabled; low clears the counter
//   count_to  : period in clk cycles
//   tick      : one-cycle pulse when the period elapses
module step_period_timer
    import stepper_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] count_to,
    output logic                tick
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_eff;

    assign period_eff = (count_to == '0) ? PERIOD_W'(1) : count_to;
    assign tick       = run && (cnt_q == period_q - PERIOD_W'(1));

    always_comb begin
        cnt_d    = cnt_q + PERIOD_W'(1);
        period_d = period_q;
        if (!run || tick) begin
            cnt_d = '0;
        end
        if (load || tick) begin
            period_d = period_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/stepper_phase_gen.sv
// stepper_phase_gen
// Walks four coil outputs through the full- or half-step excitation
// sequence at the rate set by count_to, in the direction given by dir.
//   clk, rst    : clock, synchronous active-low reset
//   bus (slave) : en, dir, step (1=full), count_to in;
//                 coils, step_tick, running (, position) out
//   HOLD_TORQUE : 1 keeps the last pattern energised while idle, 0 releases
// Optional: STEPPER_POS_COUNT_EN adds a signed 32-bit half-step position.
module stepper_phase_gen
    import stepper_pkg::*;
#(
    parameter bit HOLD_TORQUE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    stepper_phase_gen_if.slave  bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   stride;
    logic [3:0]         coils_q, coils_d;
    logic               load, run, tick;

    // Gating run with en stops the tick on the edge that leaves RUN.
    assign load = (state_q == IDLE) && bus.en;
    assign run  = (state_q == RUN)  && bus.en;

    step_period_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .run      (run),
        .count_to (bus.count_to),
        .tick     (tick)
    );

    assign stride = step_size(idx_q, bus.step);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en)  state_d = RUN;
            RUN:     if (!bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = bus.dir ? idx_q + stride : idx_q - stride;
        end
        // Looking at state_d makes the coils release on the same edge
        // that leaves RUN and energise on the edge that enters it.
        coils_d = '0;
        if (state_d == RUN || HOLD_TORQUE) begin
            coils_d = PHASE_TABLE[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_W'(1);
            coils_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            coils_q <= coils_d;
        end
    end

    assign bus.coils     = coils_q;
    assign bus.step_tick = tick;
    assign bus.running   = (state_q == RUN);

`ifdef STEPPER_POS_COUNT_EN
    logic signed [31:0] pos_q, pos_d;
    logic signed [31:0] pos_delta;

    assign pos_delta = 32'(stride);

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            pos_d = bus.dir ? pos_q + pos_delta : pos_q - pos_delta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign bus.position = pos_q;
`endif

endmodule

// File: tb/tb_stepper_phase_gen.sv
module tb_stepper_phase_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic        step = 1'b0;
    logic [20:0] count_to = '0;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    stepper_phase_gen_if bus_h ();
    stepper_phase_gen_if bus_n ();

    assign bus_h.en = en;
    assign bus_h.dir = dir;
    assign bus_h.step = step;
    assign bus_h.count_to = count_to;
    assign bus_n.en = en;
    assign bus_n.dir = dir;
    assign bus_n.step = step;
    assign bus_n.count_to = count_to;

    stepper_phase_gen #(.HOLD_TORQUE(1'b1)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    stepper_phase_gen #(.HOLD_TORQUE(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        cyc();
        cyc();
        n_chk++;
        if (bus_h.coils !== 4'b0000) $display("FAIL reset_coils got %b exp 0000", bus_h.coils);
        else n_pass++;
        n_chk++;
        if (bus_h.running !== 1'b0) $display("FAIL reset_running got %b exp 0", bus_h.running);
        else n_pass++;
        n_chk++;
        if (bus_h.step_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", bus_h.step_tick);
        else n_pass++;
`ifdef STEPPER_POS_COUNT_EN
        n_chk++;
        if (bus_h.position !== 32'sd0) $display("FAIL reset_position got %0d exp 0", bus_h.position);
        else n_pass++;
`endif
        rst = 1'b1;
        cyc();
        n_chk++;
        if (bus_h.coils !== 4'b1100) $display("FAIL idle_hold_coils got %b exp 1100", bus_h.coils);
        else n_pass++;
        n_chk++;
        if (bus_n.coils !== 4'b0000) $display("FAIL idle_nohold_coils got %b exp 0000", bus_n.coils);
        else n_pass++;
    endtask

    task automatic test_full_fwd();
        logic [3:0] seq [5];
        logic [3:0] exp_c;
        logic       exp_t;
        seq = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
        do_reset();
        step = 1'b1;
        dir = 1'b1;
        count_to = 21'd4;
        en = 1'b1;
        cyc();
        n_chk++;
        if (bus_h.running !== 1'b1) $display("FAIL full_running got %b exp 1", bus_h.running);
        else n_pass++;
        for (int k = 0; k <= 17; k++) begin
            if (k != 0) cyc();
            exp_t = ((k % 4) == 3);
            exp_c = seq[(k == 0) ? 0 : (k - 1) / 4];
            n_chk++;
            if (bus_h.step_tick !== exp_t) $display("FAIL full_tick k=%0d got %b exp %b", k, bus_h.step_tick, exp_t);
            else n_pass++;
            n_chk++;
            if (bus_n.coils !== exp_c) $display("FAIL full_coils k=%0d got %b exp %b", k, bus_n.coils, exp_c);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_half_rev();
        logic [3:0] seq [5];
        logic [3:0] exp_c;
        logic       exp_t;
        seq = '{4'b1100, 4'b1000, 4'b1001, 4'b0001, 4'b0011};
        do_reset();
        step = 1'b0;
        dir = 1'b0;
        count_to = 21'd3;
        en = 1'b1;
        cyc();
        for (int k = 0; k <= 13; k++) begin
            if (k != 0) cyc();
            exp_t = ((k % 3) == 2);
            exp_c = seq[(k == 0) ? 0 : (k - 1) / 3];
            n_chk++;
            if (bus_h.step_tick !== exp_t) $display("FAIL half_tick k=%0d got %b exp %b", k, bus_h.step_tick, exp_t);
            else n_pass++;
            n_chk++;
            if (bus_h.coils !== exp_c) $display("FAIL half_coils k=%0d got %b exp %b", k, bus_h.coils, exp_c);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_realign();
        do_reset();
        step = 1'b0;
        dir = 1'b1;
        count_to = 21'd2;
        en = 1'b1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 2) step = 1'b1;
            if (k == 3) begin
                n_chk++;
                if (bus_h.coils !== 4'b0100) $display("FAIL realign_idx2 got %b exp 0100", bus_h.coils);
                else n_pass++;
            end
            if (k == 5) begin
                n_chk++;
                if (bus_h.coils !== 4'b0110) $display("FAIL realign_idx3 got %b exp 0110", bus_h.coils);
                else n_pass++;
            end
            if (k == 7) begin
                n_chk++;
                if (bus_h.coils !== 4'b0011) $display("FAIL realign_idx5 got %b exp 0011", bus_h.coils);
                else n_pass++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_period_change();
        logic exp_t;
        do_reset();
        step = 1'b1;
        dir = 1'b1;
        count_to = 21'd10;
        en = 1'b1;
        cyc();
        for (int k = 0; k <= 15; k++) begin
            if (k != 0) cyc();
            exp_t = (k == 9) || (k > 9 && ((k - 9) % 2) == 0);
            n_chk++;
            if (bus_h.step_tick !== exp_t) $display("FAIL period_tick k=%0d got %b exp %b", k, bus_h.step_tick, exp_t);
            else n_pass++;
            if (k == 3) count_to = 21'd2;
        end
        en = 1'b0;
    endtask

    task automatic test_zero_period_hold();
        logic [3:0] exp_c [4];
        exp_c = '{4'b1100, 4'b1100, 4'b0110, 4'b0011};
        do_reset();
        step = 1'b1;
        dir = 1'b1;
        count_to = 21'd0;
        en = 1'b1;
        cyc();
        for (int k = 0; k <= 3; k++) begin
            if (k != 0) cyc();
            n_chk++;
            if (bus_n.step_tick !== 1'b1) $display("FAIL zero_tick k=%0d got %b exp 1", k, bus_n.step_tick);
            else n_pass++;
            n_chk++;
            if (bus_n.coils !== exp_c[k]) $display("FAIL zero_coils k=%0d got %b exp %b", k, bus_n.coils, exp_c[k]);
            else n_pass++;
        end
        en = 1'b0;
        cyc();
        n_chk++;
        if (bus_n.coils !== 4'b0000) $display("FAIL drop_nohold_coils got %b exp 0000", bus_n.coils);
        else n_pass++;
        n_chk++;
        if (bus_h.coils !== 4'b1001) $display("FAIL drop_hold_coils got %b exp 1001", bus_h.coils);
        else n_pass++;
        n_chk++;
        if (bus_n.running !== 1'b0) $display("FAIL drop_running got %b exp 0", bus_n.running);
        else n_pass++;
        n_chk++;
        if (bus_n.step_tick !== 1'b0) $display("FAIL drop_tick got %b exp 0", bus_n.step_tick);
        else n_pass++;
        en = 1'b1;
        cyc();
        n_chk++;
        if (bus_n.coils !== 4'b1001) $display("FAIL resume_coils got %b exp 1001", bus_n.coils);
        else n_pass++;
        n_chk++;
        if (bus_n.running !== 1'b1) $display("FAIL resume_running got %b exp 1", bus_n.running);
        else n_pass++;
        cyc();
        cyc();
        n_chk++;
        if (bus_n.coils !== 4'b1100) $display("FAIL resume_wrap_coils got %b exp 1100", bus_n.coils);
        else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_position_reset();
        do_reset();
        step = 1'b1;
        dir = 1'b1;
        count_to = 21'd1;
        en = 1'b1;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 5) begin
                dir = 1'b0;
                step = 1'b0;
            end
        end
        n_chk++;
        if (bus_h.coils !== 4'b1100) $display("FAIL pos_run_coils got %b exp 1100", bus_h.coils);
        else n_pass++;
`ifdef STEPPER_POS_COUNT_EN
        n_chk++;
        if (bus_h.position !== 32'sd7) $display("FAIL position got %0d exp 7", bus_h.position);
        else n_pass++;
`endif
        rst = 1'b0;
        cyc();
        n_chk++;
        if (bus_h.coils !== 4'b0000) $display("FAIL midrun_reset_coils got %b exp 0000", bus_h.coils);
        else n_pass++;
        n_chk++;
        if (bus_h.running !== 1'b0) $display("FAIL midrun_reset_running got %b exp 0", bus_h.running);
        else n_pass++;
`ifdef STEPPER_POS_COUNT_EN
        n_chk++;
        if (bus_h.position !== 32'sd0) $display("FAIL midrun_reset_position got %0d exp 0", bus_h.position);
        else n_pass++;
`endif
        rst = 1'b1;
        en = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_realign();
        test_period_change();
        test_zero_period_hold();
        test_position_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stepper_phase_gen.md
# stepper_phase_gen

Downstream stage of the speed controller. Consumes the 21-bit `count_to` period word and the full/half `step` mode, divides the system clock down to step ticks, and walks the four coil outputs through the full-step or half-step excitation sequence in the selected direction. It drives the motor driver inputs directly.

## Interface
- `HOLD_TORQUE`, default 1: 1 keeps the last coil pattern energised while disabled; 0 forces coils to 4'b0000 while disabled.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low
- `en`  in  1  run request; 1 = stepping
- `dir`  in  1  1 = forward (index increments), 0 = reverse
- `step`  in  1  1 = full-step, 0 = half-step (same encoding as the speed controller)
- `count_to`  in  21  step period in clk cycles, from the speed controller
- `coils`  out  4  coil drive {A, B, C, D}
- `step_tick`  out  1  one-cycle pulse on each phase advance
- `running`  out  1  FSM is in RUN
- `position`  out  32  signed half-step position; present only with `STEPPER_POS_COUNT_EN`

## Operation
- Phase table, 3-bit index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Full-step uses the odd entries (two coils on). Half-step uses all eight entries.
- FSM has two states:
  - IDLE: counter held at 0. `coils` = table[idx] if `HOLD_TORQUE`, else 0000.
  - RUN: counter active.
- Transitions:
  - IDLE→RUN when `en`=1. The period register is loaded on the same edge.
  - RUN→IDLE on the first cycle `en`=0. The counter is cleared, and no tick is issued on that edge.
- Period register: `period` = `count_to`, except `count_to`=0 is loaded as 1. It is reloaded only on IDLE→RUN entry and on every tick, so a `count_to` change mid-period takes effect from the next period.
- Counter behaviour in RUN:
  - `cnt` increments each cycle.
  - When `cnt == period-1`, `cnt` returns to 0, `step_tick`=1 and the index advances.
  - Result: one tick every `period` cycles.
- Index advance, sampled at the tick:
  - Half-step: idx ± 1.
  - Full-step, idx odd: idx ± 2.
  - Full-step, idx even (left over from half-step): idx ± 1, which realigns to odd.
  - "+" applies when `dir`=1. Arithmetic is modulo 8 and wraps 7↔0.
- `dir` and `step` are sampled only at the tick. Changing them mid-period has no effect until that tick.
- Reset values: idx=1, `coils`=0000, `cnt`=0, `period`=0, `step_tick`=0, `running`=0, `position`=0, state IDLE.
- The first RUN cycle after reset drives table[1]=1100.
- `coils` is a registered output: table[idx] is valid the cycle after idx updates.

## Timing
- `en` rising at edge N: `running`=1 after N. The first `step_tick` is high during cycle N+`period`, and `coils` changes at edge N+`period`+1.
- Tick-to-tick spacing is exactly `period` cycles, with no gap on period reload.
- `en` falling: `running`=0 one cycle later. Coils follow `HOLD_TORQUE` from that edge.
- Reset mid-run: all registers return to reset values on the next edge, regardless of `en`.
- Reset has priority over everything else.

## Configuration
- `STEPPER_POS_COUNT_EN` defined:
  - `position` port and a 32-bit signed register are present.
  - Each tick adds ±1 (half-step) or ±2 (full-step from odd idx) or ±1 (realign), signed by `dir`.
  - Wraps in two's complement.
- `STEPPER_POS_COUNT_EN` undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Shared package `stepper_pkg`:
  - phase table constant (8×4)
  - FSM state typedef {IDLE, RUN}
  - `PERIOD_W` = 21 and `IDX_W` = 3
- One sub-module, `step_period_timer`, contains:
  - the period register, the counter and tick generation
  - inputs `load`, `run`, `count_to`; output `tick`
- The top level holds the FSM, index logic, coil register and position counter.

## Test plan
- Reset then `en`=1, `step`=1, `dir`=1, `count_to`=4:
  - ticks at 4-cycle spacing
  - coils 1100→0110→0011→1001→1100
  - first tick 4 cycles after `en`
- `step`=0, `dir`=0, `count_to`=3 from idx 1: coils 1100→1000→1001→0001→0011, ticks every 3 cycles.
- In half-step, stop at idx 2 (0100), switch to full-step forward: next tick drives 0110 (idx 3), then 0011.
- `count_to` changes 10→2 mid-period: the current period still lasts 10 cycles, and the following periods last 2.
- `count_to`=0: a tick every cycle. Drop `en` with `HOLD_TORQUE`=0: coils 0000 next cycle. Re-enable: the pattern resumes from the held idx.
- With `STEPPER_POS_COUNT_EN`: 5 forward full ticks then 3 reverse half ticks from reset gives `position`=7. Assert `rst` mid-run: `position`=0 and coils 0000 the next cycle.
